// File: rtl/filt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// filt_seq_ctrl
//   Hardware initiator for the filters IP. Buffers XADC samples in a small
//   FIFO, issues one filter request per sample over filt_start/filt_done,
//   collects each result and presents it on a valid/ready output stream.
//   Filter selection 2'b11 bypasses the filters IP entirely.
//
// Ports
//   clk, rstn          : clock (rising edge), async active-low reset
//   en                 : sequencer enable (0 = finish current sample, then idle)
//   adc_data/adc_valid : incoming sample, one-cycle strobe
//   adc_overflow       : sticky, a sample was dropped because the FIFO was full
//   filt_sel_in        : requested filter (00 LPF, 01 HPF, 10 BPF, 11 bypass)
//   filt_start/filt_select/filt_input : request to the filters IP
//   filt_result/filt_done             : response from the filters IP (level)
//   m_data/m_valid/m_ready            : output result stream
//   busy               : FSM not idle or FIFO not empty
//   timeout_err        : sticky, filt_done never arrived for some request
//   sample_cnt         : number of delivered results (wraps)
//   state_dbg          : current FSM state encoding
//
// Output stream handshake: m_data is valid while m_valid=1 and is held stable
// until a cycle with m_valid=1 and m_ready=1; that cycle is the transfer.
// m_valid never drops without a transfer (except on reset).
// -----------------------------------------------------------------------------
module filt_seq_ctrl #(
    parameter int XADC_DATA_SIZE = 16,
    parameter int FIFO_AW        = 3,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      en,
    input  logic [XADC_DATA_SIZE-1:0] adc_data,
    input  logic                      adc_valid,
    output logic                      adc_overflow,
    input  logic [1:0]                filt_sel_in,
    output logic                      filt_start,
    output logic [1:0]                filt_select,
    output logic [XADC_DATA_SIZE-1:0] filt_input,
    input  logic [XADC_DATA_SIZE-1:0] filt_result,
    input  logic                      filt_done,
    output logic [XADC_DATA_SIZE-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [31:0]               sample_cnt,
    output logic [2:0]                state_dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + START_CYCLES) + 1;
    localparam logic [CW-1:0] START_LAST   = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WAIT_LOW  = 3'd4,
        S_OUT       = 3'd5
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;

    // ---------------- input FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [XADC_DATA_SIZE-1:0] mem [2**FIFO_AW];
    logic [FIFO_AW:0]          wr_ptr, rd_ptr;
    logic                      fifo_empty, fifo_full, push, pop;
    logic [XADC_DATA_SIZE-1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                        (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // LOAD is only entered with a non-empty FIFO, so a pop is always legal.
    assign pop  = (state == S_LOAD);
    // A full FIFO still accepts a sample when the head leaves the same cycle.
    assign push = adc_valid && (!fifo_full || pop);
    assign head = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            adc_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (adc_valid && !push) adc_overflow <= 1'b1;
        end
    end

    // ---------------- sequencer FSM ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (en && !fifo_empty) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (filt_sel_in == 2'b11) state_nx = S_OUT;
                else                      state_nx = S_START;
            end
            S_START: begin
                if (cnt == START_LAST) state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done arriving on the last allowed cycle still wins.
                if (filt_done)                 state_nx = S_WAIT_LOW;
                else if (cnt == TIMEOUT_LAST)  state_nx = S_IDLE;
            end
            S_WAIT_LOW: begin
                // Hold off the next request until the IP has dropped done.
                if (!filt_done) state_nx = S_OUT;
            end
            S_OUT: begin
                if (m_ready) begin
                    if (en && !fifo_empty) state_nx = S_LOAD;
                    else                   state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= '0;
            filt_start  <= 1'b0;
            filt_select <= 2'b00;
            filt_input  <= '0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            timeout_err <= 1'b0;
            sample_cnt  <= '0;
        end else begin
            state <= state_nx;
            // Per-state cycle counter, zero on the first cycle of every state.
            cnt        <= (state_nx != state) ? '0 : cnt + 1'b1;
            filt_start <= (state_nx == S_START);
            m_valid    <= (state_nx == S_OUT);

            if (state == S_LOAD) begin
                filt_input <= head;
                if (filt_sel_in == 2'b11) begin
                    m_data <= head;
                end else begin
                    filt_select <= filt_sel_in;
                end
            end

            if (state == S_WAIT_DONE) begin
                if (filt_done) begin
                    m_data <= filt_result;
                end else if (cnt == TIMEOUT_LAST) begin
                    timeout_err <= 1'b1;
                end
            end

            if (state == S_OUT && m_ready) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
        end
    end

    assign busy      = (state != S_IDLE) || !fifo_empty;
    assign state_dbg = state;

endmodule
